// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 64;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  function automatic logic [1:0] portMask(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Request/response bus between the two requesters and the arbiter.
// rsp_err only exists when DM_ARB_RANGE_CHECK_EN is defined.
interface dm_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 7
) ();

  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_we;
  logic [AW-1:0] req_addr0;
  logic [AW-1:0] req_addr1;
  logic [DW-1:0] req_wdata0;
  logic [DW-1:0] req_wdata1;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
`ifdef DM_ARB_RANGE_CHECK_EN
  logic [1:0]    rsp_err;
`endif

  modport master (
    output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
`ifdef DM_ARB_RANGE_CHECK_EN
    input  rsp_err,
`endif
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
`ifdef DM_ARB_RANGE_CHECK_EN
    output rsp_err,
`endif
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-way round-robin pick; last grant only advances on an accepted request.
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid_i,
  input  logic       accept_i,
  output logic       winner_o,
  output logic       any_o
);

  logic lastGrant_q;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    any_o = |req_valid_i;
    if (&req_valid_i) begin
      winner_o = ~lastGrant_q;
    end else begin
      winner_o = req_valid_i[1];
    end
  end

  // Resetting to the debug port makes the CPU port win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGrant_q <= PORT_DBG;
    end else if (accept_i) begin
      lastGrant_q <= winner_o;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter/sequencer sharing one data memory between two ports.
// Define DM_ARB_RANGE_CHECK_EN to suppress out-of-range accesses and flag rsp_err.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DW = dm_arb_pkg::DW,
  parameter int AW = dm_arb_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  dm_arbiter_if.slave   bus,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic          cmdWe_q, cmdWe_d;
  logic [AW-1:0] cmdAddr_q, cmdAddr_d;
  logic [DW-1:0] cmdWdata_q, cmdWdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          winner;
  logic          anyValid;
  logic          accept;
  logic          inRange;
  logic [1:0]    ready;
  logic [1:0]    rspValid;
  logic          memWrite;
  logic          memRead;

  rr_arb2 uArb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (bus.req_valid),
    .accept_i    (accept),
    .winner_o    (winner),
    .any_o       (anyValid)
  );

`ifdef DM_ARB_RANGE_CHECK_EN
  localparam logic [AW:0] DepthLim = (AW+1)'(DEPTH);
  logic [1:0] rspErr;
  assign inRange     = ({1'b0, cmdAddr_q} < DepthLim);
  assign bus.rsp_err = rspErr;
`else
  assign inRange = 1'b1;
`endif

  // Ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cmdWe_d    = cmdWe_q;
    cmdAddr_d  = cmdAddr_q;
    cmdWdata_d = cmdWdata_q;
    rdata_d    = rdata_q;
    accept     = 1'b0;
    ready      = 2'b00;
    rspValid   = 2'b00;
    memWrite   = 1'b0;
    memRead    = 1'b0;
`ifdef DM_ARB_RANGE_CHECK_EN
    rspErr     = 2'b00;
`endif
    unique case (state_q)
      IDLE: begin
        if (anyValid && rst_n) begin
          accept     = 1'b1;
          ready      = portMask(winner);
          grant_d    = winner;
          cmdWe_d    = bus.req_we[winner];
          cmdAddr_d  = winner ? bus.req_addr1 : bus.req_addr0;
          cmdWdata_d = winner ? bus.req_wdata1 : bus.req_wdata0;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        memWrite = cmdWe_q && inRange;
        memRead  = !cmdWe_q && inRange;
        if (memRead) begin
          rdata_d = mem_rdata;
        end
        state_d = RESP;
      end
      RESP: begin
        rspValid = portMask(grant_q);
`ifdef DM_ARB_RANGE_CHECK_EN
        if (!inRange) begin
          rspErr = portMask(grant_q);
        end
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command registers hold the accepted request for the whole ACCESS/RESP window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= PORT_CPU;
      cmdWe_q    <= 1'b0;
      cmdAddr_q  <= '0;
      cmdWdata_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cmdWe_q    <= cmdWe_d;
      cmdAddr_q  <= cmdAddr_d;
      cmdWdata_q <= cmdWdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_rdata = rdata_q;
  assign mem_write     = memWrite;
  assign mem_read      = memRead;
  assign mem_addr      = cmdAddr_q;
  assign mem_wdata     = cmdWdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a 64-word behavioural memory.
// Range-check scenario follows DM_ARB_RANGE_CHECK_EN.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  logic          clk;
  logic          rstN;
  logic          memWrite;
  logic          memRead;
  logic [6:0]    memAddr;
  logic [31:0]   memWdata;
  logic [31:0]   memRdata;
  logic [31:0]   mem [0:63];

  int nCompared;
  int nMismatched;

  dm_arbiter_if #(.DW(32), .AW(7)) bus ();

  dm_arbiter dut (
    .clk       (clk),
    .rst_n     (rstN),
    .bus       (bus),
    .mem_write (memWrite),
    .mem_read  (memRead),
    .mem_addr  (memAddr),
    .mem_wdata (memWdata),
    .mem_rdata (memRdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Out-of-range reads return a recognisable pattern instead of X.
  assign memRdata = (memAddr < 7'd64) ? mem[memAddr[5:0]] : (32'hBAD0_0000 | {25'd0, memAddr});

  always @(posedge clk) begin
    if (memWrite && memAddr < 7'd64) mem[memAddr[5:0]] <= memWdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    nCompared++; if (bus.req_ready !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_ready: got %b expected 00", bus.req_ready); end
    nCompared++; if (bus.rsp_valid !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid); end
    nCompared++; if (bus.rsp_rdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus.rsp_rdata); end
    nCompared++; if ({memWrite, memRead} !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_strobes: got %b expected 00", {memWrite, memRead}); end
    nCompared++; if (memAddr !== 7'h0 || memWdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_membus: got %h/%h expected 0/0", memAddr, memWdata); end
`ifdef DM_ARB_RANGE_CHECK_EN
    nCompared++; if (bus.rsp_err !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_err: got %b expected 00", bus.rsp_err); end
`endif
    @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  task automatic test_single_load();
    bus.req_valid = 2'b01; bus.req_we = 2'b00; bus.req_addr0 = 7'd5;
    #1;
    nCompared++; if (bus.req_ready !== 2'b01) begin nMismatched++; $display("[TB] FAIL load_ready: got %b expected 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    #1;
    nCompared++; if (memRead !== 1'b1 || memWrite !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_strobe: got rd=%b wr=%b expected rd=1 wr=0", memRead, memWrite); end
    nCompared++; if (memAddr !== 7'd5) begin nMismatched++; $display("[TB] FAIL load_addr: got %0d expected 5", memAddr); end
    nCompared++; if (bus.req_ready !== 2'b00) begin nMismatched++; $display("[TB] FAIL load_ready_access: got %b expected 00", bus.req_ready); end
    step();
    #1;
    nCompared++; if (bus.rsp_valid !== 2'b01) begin nMismatched++; $display("[TB] FAIL load_rsp: got %b expected 01", bus.rsp_valid); end
    nCompared++; if (bus.rsp_rdata !== 32'd7) begin nMismatched++; $display("[TB] FAIL load_rdata: got %h expected 7", bus.rsp_rdata); end
    nCompared++; if (memRead !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_read_resp: got %b expected 0", memRead); end
    step();
    #1;
    nCompared++; if (bus.rsp_valid !== 2'b00) begin nMismatched++; $display("[TB] FAIL load_pulse: got %b expected 00", bus.rsp_valid); end
    step();
  endtask

  task automatic test_store_load();
    bus.req_valid = 2'b10; bus.req_we = 2'b10; bus.req_addr1 = 7'd10; bus.req_wdata1 = 32'hDEAD_BEEF;
    #1;
    nCompared++; if (bus.req_ready !== 2'b10) begin nMismatched++; $display("[TB] FAIL store_ready: got %b expected 10", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    #1;
    nCompared++; if (memWrite !== 1'b1 || memRead !== 1'b0) begin nMismatched++; $display("[TB] FAIL store_strobe: got wr=%b rd=%b expected wr=1 rd=0", memWrite, memRead); end
    nCompared++; if (memAddr !== 7'd10 || memWdata !== 32'hDEAD_BEEF) begin nMismatched++; $display("[TB] FAIL store_bus: got %0d/%h expected 10/deadbeef", memAddr, memWdata); end
    step();
    #1;
    nCompared++; if (memWrite !== 1'b0) begin nMismatched++; $display("[TB] FAIL store_one_cycle: got %b expected 0", memWrite); end
    nCompared++; if (bus.rsp_valid !== 2'b10) begin nMismatched++; $display("[TB] FAIL store_ack: got %b expected 10", bus.rsp_valid); end
    nCompared++; if (bus.rsp_rdata !== 32'd7) begin nMismatched++; $display("[TB] FAIL store_keeps_rdata: got %h expected 7", bus.rsp_rdata); end
    step();
    bus.req_valid = 2'b10; bus.req_we = 2'b00;
    #1;
    step();
    bus.req_valid = 2'b00;
    #1;
    step();
    #1;
    nCompared++; if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 32'hDEAD_BEEF) begin nMismatched++; $display("[TB] FAIL reload: got %b/%h expected 10/deadbeef", bus.rsp_valid, bus.rsp_rdata); end
    step();
  endtask

  task automatic test_contention();
    logic g;
    bus.req_valid = 2'b11; bus.req_we = 2'b00; bus.req_addr0 = 7'd1; bus.req_addr1 = 7'd2;
    for (int i = 0; i < 6; i++) begin
      g = i[0];
      #1;
      nCompared++; if (bus.req_ready !== (g ? 2'b10 : 2'b01)) begin nMismatched++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", i, bus.req_ready, g ? 2'b10 : 2'b01); end
      nCompared++; if (bus.rsp_valid !== 2'b00) begin nMismatched++; $display("[TB] FAIL rr_idle_rsp[%0d]: got %b expected 00", i, bus.rsp_valid); end
      step();
      #1;
      nCompared++; if (bus.req_ready !== 2'b00 || memAddr !== (g ? 7'd2 : 7'd1)) begin nMismatched++; $display("[TB] FAIL rr_access[%0d]: got rdy=%b addr=%0d expected rdy=00 addr=%0d", i, bus.req_ready, memAddr, g ? 2 : 1); end
      step();
      #1;
      nCompared++; if (bus.rsp_valid !== (g ? 2'b10 : 2'b01)) begin nMismatched++; $display("[TB] FAIL rr_rsp[%0d]: got %b expected %b", i, bus.rsp_valid, g ? 2'b10 : 2'b01); end
      nCompared++; if (bus.rsp_rdata !== (g ? 32'h102 : 32'h101)) begin nMismatched++; $display("[TB] FAIL rr_rdata[%0d]: got %h expected %h", i, bus.rsp_rdata, g ? 32'h102 : 32'h101); end
      step();
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_back_to_back();
    bus.req_valid = 2'b10; bus.req_we = 2'b00; bus.req_addr1 = 7'd3;
    #1;
    nCompared++; if (bus.req_ready !== 2'b10) begin nMismatched++; $display("[TB] FAIL bp_first_ready: got %b expected 10", bus.req_ready); end
    step();
    bus.req_valid = 2'b01; bus.req_we = 2'b01; bus.req_addr0 = 7'd4; bus.req_wdata0 = 32'hAAAA_5555;
    #1;
    nCompared++; if (bus.req_ready !== 2'b00) begin nMismatched++; $display("[TB] FAIL bp_ready_access: got %b expected 00", bus.req_ready); end
    step();
    #1;
    nCompared++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b10) begin nMismatched++; $display("[TB] FAIL bp_resp: got rdy=%b rsp=%b expected rdy=00 rsp=10", bus.req_ready, bus.rsp_valid); end
    step();
    #1;
    nCompared++; if (bus.req_ready !== 2'b01) begin nMismatched++; $display("[TB] FAIL bp_ready_idle: got %b expected 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00; bus.req_addr0 = 7'd9; bus.req_wdata0 = 32'h0;
    #1;
    nCompared++; if (memWrite !== 1'b1 || memAddr !== 7'd4 || memWdata !== 32'hAAAA_5555) begin nMismatched++; $display("[TB] FAIL bp_sampled: got wr=%b %0d/%h expected wr=1 4/aaaa5555", memWrite, memAddr, memWdata); end
    step();
    #1;
    nCompared++; if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 32'h103) begin nMismatched++; $display("[TB] FAIL bp_ack: got %b/%h expected 01/103", bus.rsp_valid, bus.rsp_rdata); end
    step();
  endtask

  task automatic test_range();
    bus.req_valid = 2'b01; bus.req_we = 2'b00; bus.req_addr0 = 7'd64;
    #1;
    nCompared++; if (bus.req_ready !== 2'b01) begin nMismatched++; $display("[TB] FAIL range_ready: got %b expected 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    #1;
`ifdef DM_ARB_RANGE_CHECK_EN
    nCompared++; if (memRead !== 1'b0 || memWrite !== 1'b0) begin nMismatched++; $display("[TB] FAIL range_blocked: got rd=%b wr=%b expected 0/0", memRead, memWrite); end
    step();
    #1;
    nCompared++; if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 2'b01) begin nMismatched++; $display("[TB] FAIL range_err: got rsp=%b err=%b expected 01/01", bus.rsp_valid, bus.rsp_err); end
    nCompared++; if (bus.rsp_rdata !== 32'h103) begin nMismatched++; $display("[TB] FAIL range_rdata: got %h expected 103", bus.rsp_rdata); end
`else
    nCompared++; if (memRead !== 1'b1 || memAddr !== 7'd64) begin nMismatched++; $display("[TB] FAIL range_pass: got rd=%b addr=%0d expected 1/64", memRead, memAddr); end
    step();
    #1;
    nCompared++; if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 32'hBAD0_0040) begin nMismatched++; $display("[TB] FAIL range_rdata: got %b/%h expected 01/bad00040", bus.rsp_valid, bus.rsp_rdata); end
`endif
    step();
    bus.req_valid = 2'b01; bus.req_addr0 = 7'd63;
    #1;
    step();
    bus.req_valid = 2'b00;
    #1;
    nCompared++; if (memRead !== 1'b1) begin nMismatched++; $display("[TB] FAIL top_word_read: got %b expected 1", memRead); end
    step();
    #1;
    nCompared++; if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 32'd31) begin nMismatched++; $display("[TB] FAIL top_word: got %b/%h expected 01/1f", bus.rsp_valid, bus.rsp_rdata); end
`ifdef DM_ARB_RANGE_CHECK_EN
    nCompared++; if (bus.rsp_err !== 2'b00) begin nMismatched++; $display("[TB] FAIL top_word_err: got %b expected 00", bus.rsp_err); end
`endif
    step();
  endtask

  task automatic test_reset_mid_store();
    bus.req_valid = 2'b01; bus.req_we = 2'b01; bus.req_addr0 = 7'd20; bus.req_wdata0 = 32'h1234_5678;
    #1;
    step();
    bus.req_valid = 2'b00;
    #1;
    nCompared++; if (memWrite !== 1'b1) begin nMismatched++; $display("[TB] FAIL mid_store_write: got %b expected 1", memWrite); end
    rstN = 1'b0;
    #1;
    nCompared++; if (memWrite !== 1'b0 || bus.rsp_valid !== 2'b00) begin nMismatched++; $display("[TB] FAIL mid_reset_async: got wr=%b rsp=%b expected 0/00", memWrite, bus.rsp_valid); end
    nCompared++; if (memAddr !== 7'd0 || bus.rsp_rdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL mid_reset_regs: got %0d/%h expected 0/0", memAddr, bus.rsp_rdata); end
    @(posedge clk);
    #1 rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      nCompared++; if (bus.rsp_valid !== 2'b00) begin nMismatched++; $display("[TB] FAIL no_stale_rsp[%0d]: got %b expected 00", i, bus.rsp_valid); end
      step();
    end
    bus.req_valid = 2'b11; bus.req_we = 2'b00; bus.req_addr0 = 7'd5; bus.req_addr1 = 7'd6;
    #1;
    nCompared++; if (bus.req_ready !== 2'b01) begin nMismatched++; $display("[TB] FAIL post_reset_tie: got %b expected 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    #1;
    step();
    #1;
    nCompared++; if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 32'd7) begin nMismatched++; $display("[TB] FAIL post_reset_load: got %b/%h expected 01/7", bus.rsp_valid, bus.rsp_rdata); end
    step();
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h100 + i;
    mem[5] = 32'd7;
    mem[63] = 32'd31;
    rstN = 1'b0;
    bus.req_valid = 2'b00; bus.req_we = 2'b00;
    bus.req_addr0 = '0; bus.req_addr1 = '0;
    bus.req_wdata0 = '0; bus.req_wdata1 = '0;
    $display("[TB] starting dm_arbiter bench");
    test_reset();
    test_single_load();
    test_store_load();
    test_contention();
    test_back_to_back();
    test_range();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
